// File: rtl/alert_if.sv
// Alert arbiter signal bundle: request/button/tick inputs
// and the buzzer-side status outputs.
interface alert_if;
  logic       tick_1hz;
  logic [1:0] req;
  logic       enter;
  logic       esc;
  logic       alm;
  logic [1:0] active;
  logic       snoozing;
  logic [1:0] missed;

  modport master (
    output tick_1hz, req, enter, esc,
    input  alm, active, snoozing, missed
  );

  modport slave (
    input  tick_1hz, req, enter, esc,
    output alm, active, snoozing, missed
  );
endinterface

// File: rtl/alert_arbiter.sv
// Buzzer arbiter for alarm (src 0) and timer (src 1):
// fixed-priority grant, snooze, dismiss and auto-timeout.
module alert_arbiter #(
  parameter int RING_S     = 60,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  alert_if.slave bus
);

  localparam logic [8:0] RING_L = 9'(RING_S);
  localparam logic [8:0] SNZ_L  = 9'(SNOOZE_S);
  localparam logic [2:0] SNZ_MX = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] req_d;
  logic       enter_d, esc_d;
  logic       armed;
  logic [1:0] pend, pend_n;
  logic [1:0] active, active_n;
  logic [1:0] missed, missed_n;
  logic [8:0] sec_cnt, sec_n, cnt_inc;
  logic [2:0] snz_cnt, snz_n;
  logic [1:0] grant;
  logic [1:0] req_rise;
  logic       enter_rise, esc_rise;

  // First cycle after reset only samples levels, so held inputs
  // must fall and rise again before they act.
  assign req_rise   = armed ? (bus.req & ~req_d) : 2'b00;
  assign enter_rise = armed & bus.enter & ~enter_d;
  assign esc_rise   = armed & bus.esc & ~esc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_d   <= '0;
      enter_d <= 1'b0;
      esc_d   <= 1'b0;
      armed   <= 1'b0;
      pend    <= '0;
      active  <= '0;
      missed  <= '0;
      sec_cnt <= '0;
      snz_cnt <= '0;
    end else begin
      state   <= state_n;
      req_d   <= bus.req;
      enter_d <= bus.enter;
      esc_d   <= bus.esc;
      armed   <= 1'b1;
      pend    <= pend_n;
      active  <= active_n;
      missed  <= missed_n;
      sec_cnt <= sec_n;
      snz_cnt <= snz_n;
    end
  end

  always_comb begin
    state_n  = state;
    active_n = active;
    missed_n = missed;
    sec_n    = sec_cnt;
    snz_n    = snz_cnt;
    grant    = 2'b00;
    cnt_inc  = sec_cnt + 9'd1;
    unique case (state)
      IDLE: begin
        if (esc_rise) missed_n = '0;
        if (pend != 2'b00) begin
          grant    = pend[0] ? 2'b01 : 2'b10;
          active_n = grant;
          sec_n    = '0;
          snz_n    = '0;
          state_n  = RING;
        end
      end
      RING: begin
        if (esc_rise) begin
          active_n = '0;
          state_n  = IDLE;
        end else if (enter_rise && snz_cnt < SNZ_MX) begin
          snz_n   = snz_cnt + 3'd1;
          sec_n   = '0;
          state_n = SNOOZE;
        end else if (enter_rise) begin
          active_n = '0;
          state_n  = IDLE;
        end else if (bus.tick_1hz) begin
          if (cnt_inc == RING_L) begin
            missed_n = missed | active;
            active_n = '0;
            state_n  = IDLE;
          end else begin
            sec_n = cnt_inc;
          end
        end
      end
      SNOOZE: begin
        if (esc_rise) begin
          active_n = '0;
          state_n  = IDLE;
        end else if (bus.tick_1hz) begin
          if (cnt_inc == SNZ_L) begin
            sec_n   = '0;
            state_n = RING;
          end else begin
            sec_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    pend_n = (pend & ~grant) | (req_rise & ~active & ~grant);
  end

  assign bus.alm      = (state == RING);
  assign bus.snoozing = (state == SNOOZE);
  assign bus.active   = active;
  assign bus.missed   = missed;

endmodule

// File: tb/tb_alert_arbiter.sv
// Scenario bench for alert_arbiter with short ring/snooze limits;
// expected outputs are queued per step and popped after each edge.
module tb_alert_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [5:0] exp_q[$];

  typedef struct packed {
    logic [1:0] r;
    logic       en;
    logic       es;
    logic       tk;
    logic [5:0] e;
  } step_t;

  alert_if a ();

  alert_arbiter #(
    .RING_S(3),
    .SNOOZE_S(2),
    .MAX_SNOOZE(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(a.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {a.alm, a.active, a.snoozing, a.missed};
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    a.req = s.r;
    a.enter = s.en;
    a.esc = s.es;
    a.tick_1hz = s.tk;
    exp_q.push_back(s.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    a.req = 2'b00;
    a.enter = 1'b0;
    a.esc = 1'b0;
    a.tick_1hz = 1'b0;
    rst_n = 1'b0;
    exp_q.push_back(6'b000000);
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset: got %b want %b", obs(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    step_t s[4] = '{
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b0, 1'b1, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000}
    };
    logic [5:0] e;
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL basic[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_priority();
    step_t s[7] = '{
      '{2'b11, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b11, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b11, 1'b0, 1'b1, 1'b0, 6'b000000},
      '{2'b11, 1'b0, 1'b1, 1'b0, 6'b110000},
      '{2'b11, 1'b0, 1'b0, 1'b0, 6'b110000},
      '{2'b11, 1'b0, 1'b1, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000}
    };
    logic [5:0] e;
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL priority[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s[9] = '{
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b101000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b101000},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b000001},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000001},
      '{2'b01, 1'b0, 1'b1, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000}
    };
    logic [5:0] e;
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL timeout[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_snooze();
    step_t s[8] = '{
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b1, 1'b0, 1'b0, 6'b001100},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b001100},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b001100},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b101000},
      '{2'b01, 1'b1, 1'b0, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000}
    };
    logic [5:0] e;
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL snooze[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_collision();
    step_t s[10] = '{
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b1, 1'b1, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b101000},
      '{2'b01, 1'b0, 1'b0, 1'b1, 6'b101000},
      '{2'b01, 1'b0, 1'b1, 1'b1, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000}
    };
    logic [5:0] e;
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL collision[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t pre[4] = '{
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b01, 1'b0, 1'b0, 1'b0, 6'b101000},
      '{2'b01, 1'b1, 1'b0, 1'b0, 6'b001100},
      '{2'b11, 1'b0, 1'b0, 1'b0, 6'b001100}
    };
    step_t post[7] = '{
      '{2'b11, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b11, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b10, 1'b0, 1'b0, 1'b0, 6'b000000},
      '{2'b10, 1'b0, 1'b0, 1'b0, 6'b110000},
      '{2'b10, 1'b0, 1'b1, 1'b0, 6'b000000},
      '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000}
    };
    logic [5:0] e;
    foreach (pre[i]) begin
      drive(pre[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL rstmid_pre[%0d]: got %b want %b", i, obs(), e);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.push_back(6'b000000);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rstmid_async: got %b want %b", obs(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    foreach (post[i]) begin
      drive(post[i]);
      e = exp_q.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL rstmid_post[%0d]: got %b want %b", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_timeout();
    test_snooze();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alert_arbiter.md
# alert_arbiter

Arbitrates the single buzzer output among the watch's alert sources: alarm (source 0) and timer (source 1). Requests are latched, rung one at a time with fixed priority, and acknowledged from the shared enter/esc buttons with snooze, dismiss and auto-timeout. The block sits in the top-level watch beside the mode modules. Its `alm` output replaces the direct OR of module alarm bits.

## Interface
- `RING_S`, default 60: seconds an alert rings before auto-dismiss; range 1..511.
- `SNOOZE_S`, default 300: snooze length in seconds; range 1..511.
- `MAX_SNOOZE`, default 3: snoozes allowed per alert; range 0..7.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `tick_1hz` in 1: one-cycle pulse once per second.
- `req` in 2: level alert requests; bit0 = alarm, bit1 = timer.
- `enter` in 1: active-high button level, already debounced.
- `esc` in 1: active-high button level, already debounced.
- `alm` out 1: buzzer drive; high in RING.
- `active` out 2: one-hot source currently ringing or snoozed; 0 in IDLE.
- `snoozing` out 1: high in SNOOZE.
- `missed` out 2: sticky per-source flag set when an alert times out unacknowledged.

## Operation
- Reset value of every output and internal register is 0: `alm`, `active`, `snoozing`, `missed`, pending, edge registers, counters, state = IDLE.
- Edge detect: registered copies `req_d`, `enter_d` and `esc_d`. A rise means the current value is 1 and the registered value is 0. Level-held inputs act once.
- Pending latch: a rise on `req[i]` sets `pend[i]`, unless `i` is the active source. A rise for the active source is dropped.
- States:
  - IDLE: if `pend` ≠ 0, grant the lowest set bit (alarm beats timer). Clear that `pend` bit, load `active`, clear sec_cnt and snz_cnt, go to RING. An esc rise in IDLE clears `missed`.
  - RING: `alm` = 1. The count increments on `tick_1hz`.
    - esc rise: dismiss → IDLE, `active` = 0.
    - Else enter rise with snz_cnt < MAX_SNOOZE: snz_cnt++, sec_cnt = 0, → SNOOZE.
    - Else enter rise with snz_cnt = MAX_SNOOZE: dismiss → IDLE.
    - Else, when the count reaches RING_S: set `missed[active]`, → IDLE.
  - SNOOZE: `alm` = 0, `snoozing` = 1, `active` held.
    - esc rise: dismiss → IDLE.
    - Enter is ignored.
    - When the count reaches SNOOZE_S: sec_cnt = 0, → RING (same source, snz_cnt kept).
- Pending requests for the other source wait through RING and SNOOZE. They are granted from IDLE after the current alert ends.
- Counter: one 9-bit sec_cnt, and a compare against RING_S or SNOOZE_S depending on state. snz_cnt is 3 bits. Neither counter wraps, because the state exits at the compare.
- Simultaneous events:
  - esc beats enter.
  - esc beats timeout in the same cycle; `missed` is not set.
  - A request rise in the grant cycle for the other source is latched normally.
  - Both request bits rising together: alarm is granted, timer stays pending.

## Timing
- Request `req[i]` first sampled high at edge k: `pend[i]` = 1 after edge k. The grant happens at edge k+1, so `alm` and `active` are valid after k+1 (2-cycle latency from IDLE).
- Button rise sampled at edge k: the state change is visible after edge k.
- `tick_1hz` sampled at edge k: the count is updated after k. A timeout transition happens at the edge where the incremented value equals the limit. RING therefore lasts exactly RING_S ticks after entry.
- After dismiss, a waiting pending alert is granted on the next edge, with one IDLE cycle between.
- Async reset mid-RING or mid-SNOOZE: all outputs drop to 0 immediately. Pending requests are lost, and a level-held `req` is not re-detected until it falls and rises again.

## Test plan
- Basic ring and dismiss: reset, raise `req[0]`, hold.
  - Expect `alm` = 1 and `active` = 01 two cycles after the rise.
  - Pulse esc: `alm` = 0, `active` = 00 the next cycle.
- Priority and queue: `req` = 11 in the same cycle.
  - Expect `active` = 01.
  - esc: one IDLE cycle, then `active` = 10, `alm` = 1.
- Timeout: RING_S = 3, three `tick_1hz` pulses, no buttons.
  - Expect `alm` to fall on the 3rd tick and `missed` = 01.
  - esc in IDLE clears `missed` to 00.
- Snooze: MAX_SNOOZE = 1, SNOOZE_S = 2.
  - enter: `snoozing` = 1, `alm` = 0.
  - After 2 ticks: `alm` = 1 again.
  - enter again: dismiss to IDLE, not snooze.
- Collisions: esc and enter rise together in RING → IDLE. esc on the same cycle as the timeout tick → IDLE with `missed` = 00.
- Reset mid-operation: assert `rst_n` = 0 during SNOOZE with `pend[1]` set.
  - Expect all outputs 0 asynchronously.
  - After release, the held `req` does not ring until it rises again.
